dtree_mc: RTL and testbench

DTREE_MC -- requirements
Module: dtree_mc

---
 rtl/dtree_mc.sv | 203 ++++++++++++++++++++
 tb/tb_dtree_mc.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtree_mc.sv
// dtree_mc: multichannel oblique decision-tree classifier, one multiply-accumulate per cycle.
// Define DTREE_MC_SKIP_ZERO_EN to skip MAC cycles whose coefficient is zero (latency only).
module dtree_mc #(
  parameter int CHANNELS    = 4,
  parameter int FEATURES    = 3,
  parameter int DEPTH       = 2,
  parameter int IN_WIDTH    = 10,
  parameter int COEFF_WIDTH = 4,
  localparam int NODES = (1 << DEPTH) - 1,
  localparam int CHW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int NW    = $clog2(NODES + 1),
  localparam int FW    = $clog2(FEATURES + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHW-1:0]             in_channel,
  input  logic signed [IN_WIDTH-1:0] sample,
  input  logic                       cfg_we,
  input  logic [NW-1:0]              cfg_node,
  input  logic [FW-1:0]              cfg_feat,
  input  logic [IN_WIDTH-1:0]        cfg_data,
  output logic                       cfg_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CHW-1:0]             out_channel,
  output logic [DEPTH-1:0]           out_leaf,
  output logic [1:0]                 dbg_state_o
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and ready depends only on registered state.
  localparam int AW = IN_WIDTH + COEFF_WIDTH + $clog2(FEATURES) + 1;
  localparam int LW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = IN_WIDTH + COEFF_WIDTH;

  typedef enum logic [1:0] {COLLECT = 2'd0, EVAL = 2'd1, DONE = 2'd2} state_t;

  state_t                     state_q, state_d;
  logic [FW-1:0]              cnt_q, cnt_d, f_q, f_d;
  logic [NW-1:0]              node_q, node_d, node_nx;
  logic [LW-1:0]              lvl_q, lvl_d;
  logic [DEPTH-1:0]           path_q, path_d;
  logic [CHW-1:0]             chan_q, chan_d;
  logic signed [AW-1:0]       acc_q, acc_d;

  logic signed [COEFF_WIDTH-1:0] coef_q [NODES][FEATURES];
  logic signed [IN_WIDTH-1:0]    bias_q [NODES];
  logic signed [IN_WIDTH-1:0]    feat_q [FEATURES];

  logic                       beat_acc, cfg_acc, dec_bit;
  logic [FW-1:0]              f_sel, first0_c, first_nx_c, next_f_c;
  logic signed [PW-1:0]       prod;
  logic signed [IN_WIDTH-1:0] bias0_eff;

  function automatic logic signed [AW-1:0] bias_ext(input logic signed [IN_WIDTH-1:0] b);
    logic signed [AW-1:0] w;
    w = AW'(b);
    return w <<< (COEFF_WIDTH - 1);
  endfunction

  assign in_ready    = (state_q == COLLECT);
  assign cfg_ready   = in_ready && (cnt_q == '0);
  assign out_valid   = (state_q == DONE);
  assign out_channel = chan_q;
  assign out_leaf    = path_q;
  assign dbg_state_o = state_q;

  assign beat_acc = in_valid && in_ready;
  assign cfg_acc  = cfg_we && cfg_ready && (int'(cfg_node) < NODES) && (int'(cfg_feat) <= FEATURES);

  // A bias write landing on the last beat must already be seen when node 0 is loaded.
  assign bias0_eff = (cfg_acc && cfg_node == '0 && int'(cfg_feat) == FEATURES) ?
                     cfg_data : bias_q[0];

  assign f_sel   = (int'(f_q) < FEATURES) ? f_q : '0;
  assign prod    = PW'(coef_q[node_q][f_sel]) * PW'(feat_q[f_sel]);
  assign dec_bit = acc_q[AW-1];
  assign node_nx = NW'(2 * int'(node_q) + 1 + int'(dec_bit));

`ifdef DTREE_MC_SKIP_ZERO_EN
  logic [FEATURES*COEFF_WIDTH-1:0] row_c [NODES];
  logic [FEATURES*COEFF_WIDTH-1:0] row0_eff;

  function automatic logic [FW-1:0] first_nz(input logic [FEATURES*COEFF_WIDTH-1:0] row,
                                             input int start);
    logic [FW-1:0] idx;
    idx = FW'(FEATURES);
    for (int f = FEATURES - 1; f >= 0; f--)
      if (f >= start && row[f*COEFF_WIDTH +: COEFF_WIDTH] != '0) idx = FW'(f);
    return idx;
  endfunction

  always_comb begin
    for (int n = 0; n < NODES; n++)
      for (int f = 0; f < FEATURES; f++)
        row_c[n][f*COEFF_WIDTH +: COEFF_WIDTH] = coef_q[n][f];
    row0_eff = row_c[0];
    if (cfg_acc && cfg_node == '0 && int'(cfg_feat) < FEATURES)
      row0_eff[int'(cfg_feat)*COEFF_WIDTH +: COEFF_WIDTH] = cfg_data[COEFF_WIDTH-1:0];
  end

  assign first0_c   = first_nz(row0_eff, 0);
  assign first_nx_c = first_nz(row_c[node_nx], 0);
  assign next_f_c   = first_nz(row_c[node_q], int'(f_q) + 1);
`else
  assign first0_c   = '0;
  assign first_nx_c = '0;
  assign next_f_c   = FW'(int'(f_q) + 1);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    node_d  = node_q;
    lvl_d   = lvl_q;
    path_d  = path_q;
    chan_d  = chan_q;
    acc_d   = acc_q;
    case (state_q)
      COLLECT: begin
        if (beat_acc) begin
          if (cnt_q == '0) chan_d = in_channel;
          if (int'(cnt_q) == FEATURES - 1) begin
            cnt_d   = '0;
            state_d = EVAL;
            node_d  = '0;
            lvl_d   = '0;
            path_d  = '0;
            f_d     = first0_c;
            acc_d   = bias_ext(bias0_eff);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      EVAL: begin
        if (int'(f_q) < FEATURES) begin
          acc_d = acc_q + AW'(prod);
          f_d   = next_f_c;
        end else begin
          // Decision cycle: sign of the finished sum picks the child.
          path_d = DEPTH'({path_q, dec_bit});
          if (int'(lvl_q) == DEPTH - 1) begin
            state_d = DONE;
          end else begin
            node_d = node_nx;
            lvl_d  = lvl_q + 1'b1;
            f_d    = first_nx_c;
            acc_d  = bias_ext(bias_q[node_nx]);
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      f_q     <= '0;
      node_q  <= '0;
      lvl_q   <= '0;
      path_q  <= '0;
      chan_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      node_q  <= node_d;
      lvl_q   <= lvl_d;
      path_q  <= path_d;
      chan_q  <= chan_d;
      acc_q   <= acc_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < NODES; n++) begin
        bias_q[n] <= '0;
        for (int f = 0; f < FEATURES; f++) coef_q[n][f] <= '0;
      end
    end else if (cfg_acc) begin
      if (int'(cfg_feat) == FEATURES) bias_q[cfg_node] <= cfg_data;
      else coef_q[cfg_node][cfg_feat] <= cfg_data[COEFF_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int f = 0; f < FEATURES; f++) feat_q[f] <= '0;
    end else if (beat_acc) begin
      feat_q[cnt_q] <= sample;
    end
  end
endmodule

// File: tb/tb_dtree_mc.sv
// Directed bench for dtree_mc: hand-computed leaf/channel/latency results queued per vector.
`timescale 1ns/1ps
module tb_dtree_mc;
  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_channel = '0;
  logic signed [9:0] sample = '0;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_node = '0;
  logic [1:0]        cfg_feat = '0;
  logic [9:0]        cfg_data = '0;
  logic              cfg_ready;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [1:0]        out_channel;
  logic [1:0]        out_leaf;
  logic [1:0]        dbg_state;

  logic [11:0] exp_q[$];   // {latency[7:0], channel[1:0], leaf[1:0]}
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_beat = 0;
  bit seen = 1'b0;
  logic [1:0] cap_leaf, cap_ch;

  dtree_mc dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_channel(in_channel), .sample(sample), .cfg_we(cfg_we), .cfg_node(cfg_node),
    .cfg_feat(cfg_feat), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel),
    .out_leaf(out_leaf), .dbg_state_o(dbg_state)
  );

  // Clock / cycle bookkeeping
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (reset && in_valid && in_ready) last_beat = cyc;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [11:0] e;
    if (!reset) begin
      seen = 1'b0;
    end else if (out_valid) begin
      check("in_ready_low_while_valid", in_ready, 0);
      check("cfg_ready_low_while_valid", cfg_ready, 0);
      if (!seen) begin
        seen = 1'b1;
        cap_leaf = out_leaf;
        cap_ch = out_channel;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got leaf %0d ch %0d, expected no result", out_leaf, out_channel);
        end else begin
          e = exp_q.pop_front();
          check("leaf", out_leaf, e[1:0]);
          check("channel", out_channel, e[3:2]);
          check("latency", cyc - last_beat, e[11:4]);
        end
      end else begin
        check("hold_leaf", out_leaf, cap_leaf);
        check("hold_channel", out_channel, cap_ch);
      end
      if (out_ready) seen = 1'b0;
    end
  end

  // Driver tasks
  task automatic push(input int ch, input int leaf, input int lat_fixed, input int lat_skip);
    int lat;
`ifdef DTREE_MC_SKIP_ZERO_EN
    lat = lat_skip;
`else
    lat = lat_fixed;
`endif
    exp_q.push_back({8'(lat), 2'(ch), 2'(leaf)});
  endtask

  task automatic cfg_write(input int node, input int feat, input int data);
    cfg_we = 1'b1;
    cfg_node = 2'(node);
    cfg_feat = 2'(feat);
    cfg_data = 10'(data);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic send_vec(input int ch, input int s0, input int s1, input int s2,
                          input bit wcfg = 1'b0, input int wnode = 0, input int wfeat = 0,
                          input int wdata = 0);
    int v[3];
    v = '{s0, s1, s2};
    for (int b = 0; b < 3; b++) begin
      int n;
      bit acc;
      n = 0;
      acc = 1'b0;
      in_valid = 1'b1;
      sample = 10'(v[b]);
      in_channel = (b == 0) ? 2'(ch) : 2'(ch ^ 1);
      if (b == 0 && wcfg) begin
        cfg_we = 1'b1;
        cfg_node = 2'(wnode);
        cfg_feat = 2'(wfeat);
        cfg_data = 10'(wdata);
      end
      while (!acc && n < 200) begin
        acc = in_ready;
        @(posedge clk); #1;
        n++;
      end
      cfg_we = 1'b0;
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout: beat %0d not accepted, expected acceptance", b);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: %0d results pending, expected 0", exp_q.size());
    end
  endtask

  initial begin
    int n;
    // Reset state, asserted without any clock edge having arrived
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_leaf", out_leaf, 0);
    check("rst_out_channel", out_channel, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_cfg_ready", cfg_ready, 1);
    #11 reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_cfg_ready", cfg_ready, 1);

    // All-zero configuration
    push(2, 0, 8, 2);
    send_vec(2, 5, -3, 7);
    wait_idle();

    // Biases only: node0 -1 goes right, node2 +1 goes left
    cfg_write(0, 3, -1);
    cfg_write(2, 3, 1);
    push(1, 2, 8, 2);
    send_vec(1, 100, -100, 0);
    wait_idle();

    // Node 0 picks on the sign of feature 0
    cfg_write(0, 0, 1);
    cfg_write(0, 3, 0);
    push(3, 2, 8, 3);
    send_vec(3, -4, 9, 9);
    push(0, 0, 8, 3);
    send_vec(0, 4, 9, 9);
    wait_idle();

    // Node 1 full MAC: coeffs {-8,7,2} (low nibble of 0x3F8), bias 3
    cfg_write(1, 0, 'h3F8);
    cfg_write(1, 1, 7);
    cfg_write(1, 2, 2);
    cfg_write(1, 3, 3);
    cfg_write(3, 3, -512);
    cfg_write(3, 0, 5);
    push(1, 1, 8, 6);
    send_vec(1, 10, -20, 5);
    push(2, 0, 8, 6);
    send_vec(2, 0, 100, -50);
    push(3, 1, 8, 6);
    send_vec(3, 511, -512, 511);
    push(0, 0, 8, 6);
    send_vec(0, 0, 511, 511);
    wait_idle();

    // Back-pressure: hold 20 cycles, config write in that window must be dropped
    out_ready = 1'b0;
    push(2, 1, 8, 6);
    send_vec(2, 10, -20, 5);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("backpressure_valid_seen", out_valid, 1);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        cfg_we = 1'b1;
        cfg_node = 2'd0;
        cfg_feat = 2'd3;
        cfg_data = 10'(-64);
      end
      @(posedge clk); #1;
      cfg_we = 1'b0;
    end
    out_ready = 1'b1;
    wait_idle();
    push(1, 1, 8, 6);
    send_vec(1, 10, -20, 5);
    wait_idle();

    // Reset on cycle 3 of evaluation: no result may appear
    send_vec(2, 1, 2, 3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("mid_eval_rst_out_valid", out_valid, 0);
    check("mid_eval_rst_out_leaf", out_leaf, 0);
    check("mid_eval_rst_in_ready", in_ready, 1);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    check("mid_eval_post_rst_cfg_ready", cfg_ready, 1);
    repeat (15) @(posedge clk);
    #1;

    // Reset after one collected beat: partial vector is discarded
    in_valid = 1'b1;
    sample = 10'd3;
    in_channel = 2'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("mid_collect_rst_channel", out_channel, 0);
    #2 reset = 1'b1;
    @(posedge clk); #1;

    // Configuration was cleared by reset: everything goes left
    push(3, 0, 8, 2);
    send_vec(3, -7, 8, -9);
    wait_idle();

    // Config write in the same cycle as the first beat is used by that vector
    push(2, 2, 8, 2);
    send_vec(2, 5, 5, 5, 1'b1, 0, 3, -1);
    wait_idle();

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
